tfifo_elastic: RTL and testbench

//  Transparent elastic FIFO placed directly downstream of an opaque elastic buffer (oehb).
//  The oehb breaks the forward valid/data path; this block absorbs downstream back-pressure
//  so the oehb keeps streaming, and keeps its own ins_ready off the outs_ready path.
//  The pair forms the standard full elastic buffer in handshake circuits.
//

---
 rtl/handshake_pkg.sv | 23 ++
 rtl/tfifo_elastic_ctrl.sv | 79 +++++++
 rtl/tfifo_elastic.sv | 58 +++++
 tb/tb_tfifo_elastic.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// Shared width helpers for handshake/elastic-buffer blocks.
package handshake_pkg;

  function automatic int unsigned clog2_f(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Pointer width, never below one bit.
  function automatic int unsigned ptr_w_f(input int unsigned n);
    return (clog2_f(n) > 1) ? clog2_f(n) : 1;
  endfunction

  // Occupancy width covering 0..n inclusive.
  function automatic int unsigned cnt_w_f(input int unsigned n);
    return clog2_f(n + 1);
  endfunction

endpackage

// File: rtl/tfifo_elastic_ctrl.sv
// Dataless elastic FIFO control: pointers, occupancy and handshake decode.
// Define TFIFO_ELASTIC_BYPASS_EN for transparent (zero-latency when empty) mode.
module tfifo_elastic_ctrl
  import handshake_pkg::*;
#(
  parameter  int unsigned NUM_SLOTS = 4,
  localparam int unsigned PTR_W     = ptr_w_f(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ins_valid_i,
  output logic             ins_ready_c,
  output logic             outs_valid_c,
  input  logic             outs_ready_i,
  output logic             wr_en_c,
  output logic [PTR_W-1:0] wr_addr_o,
  output logic [PTR_W-1:0] rd_addr_o,
  output logic             empty_c
);

  localparam int unsigned      CNT_W    = cnt_w_f(NUM_SLOTS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             in_fire;
  logic             out_fire;
  logic             bypass;
  logic             rd_en;

  assign empty_c     = (count_q == '0);
  assign full        = (count_q == FULL_CNT);
  assign ins_ready_c = rst & ~full;

`ifdef TFIFO_ELASTIC_BYPASS_EN
  assign outs_valid_c = rst & (~empty_c | ins_valid_i);
  assign bypass       = empty_c & in_fire & outs_ready_i;
`else
  assign outs_valid_c = rst & ~empty_c;
  assign bypass       = 1'b0;
`endif

  assign in_fire   = ins_valid_i & ins_ready_c;
  assign out_fire  = outs_valid_c & outs_ready_i;
  assign wr_en_c   = in_fire & ~bypass;
  assign rd_en     = ~empty_c & out_fire;
  assign wr_addr_o = tail_q;
  assign rd_addr_o = head_q;

  // Pointer wrap uses an explicit compare so depth need not be a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (wr_en_c) tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
    if (rd_en)   head_d = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
    case ({wr_en_c, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tfifo_elastic.sv
// Elastic FIFO for use behind an opaque elastic buffer; storage plus output mux.
// Define TFIFO_ELASTIC_BYPASS_EN for transparent mode (empty FIFO passes ins straight to outs).
module tfifo_elastic
  import handshake_pkg::*;
#(
  parameter int unsigned DATA_TYPE = 32,
  parameter int unsigned NUM_SLOTS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] ins,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  output logic [DATA_TYPE-1:0] outs,
  output logic                 outs_valid,
  input  logic                 outs_ready
);

  localparam int unsigned PTR_W = ptr_w_f(NUM_SLOTS);

  logic [DATA_TYPE-1:0] mem_q [NUM_SLOTS];
  logic                 wr_en;
  logic [PTR_W-1:0]     wr_addr;
  logic [PTR_W-1:0]     rd_addr;
  logic                 empty;

  tfifo_elastic_ctrl #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .ins_valid_i  (ins_valid),
    .ins_ready_c  (ins_ready),
    .outs_valid_c (outs_valid),
    .outs_ready_i (outs_ready),
    .wr_en_c      (wr_en),
    .wr_addr_o    (wr_addr),
    .rd_addr_o    (rd_addr),
    .empty_c      (empty)
  );

  // Payload storage is deliberately not reset; occupancy tracking guards reads.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= ins;
  end

  always_comb begin
    outs = mem_q[rd_addr];
    if (empty) begin
`ifdef TFIFO_ELASTIC_BYPASS_EN
      outs = rst ? ins : '0;
`else
      outs = '0;
`endif
    end
  end

endmodule

// File: tb/tb_tfifo_elastic.sv
// Scoreboard bench for tfifo_elastic: 4-slot instance for handshake/reset cases, 3-slot for wrap.
module tb_tfifo_elastic;

`ifdef TFIFO_ELASTIC_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [31:0] ins4 = 32'h33;
  logic        ins_valid4 = 1'b1;
  logic        ins_ready4;
  logic [31:0] outs4;
  logic        outs_valid4;
  logic        outs_ready4 = 1'b0;

  logic [31:0] ins3 = 32'h0;
  logic        ins_valid3 = 1'b0;
  logic        ins_ready3;
  logic [31:0] outs3;
  logic        outs_valid3;
  logic        outs_ready3 = 1'b0;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp4[$];
  logic [31:0] exp3[$];
  logic        st3_q = 1'b0;
  logic [31:0] prev3_q = 32'h0;

  always #5 clk = ~clk;

  tfifo_elastic #(.DATA_TYPE(32), .NUM_SLOTS(4)) u_dut4 (
    .clk(clk), .rst(rst), .ins(ins4), .ins_valid(ins_valid4), .ins_ready(ins_ready4),
    .outs(outs4), .outs_valid(outs_valid4), .outs_ready(outs_ready4)
  );

  tfifo_elastic #(.DATA_TYPE(32), .NUM_SLOTS(3)) u_dut3 (
    .clk(clk), .rst(rst), .ins(ins3), .ins_valid(ins_valid3), .ins_ready(ins_ready3),
    .outs(outs3), .outs_valid(outs_valid3), .outs_ready(outs_ready3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Output monitors: pop expected token on every output handshake.
  always @(negedge clk) begin
    if (outs_valid4 && outs_ready4) begin
      if (exp4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL u4_unexpected_token actual=%0h required=none", outs4);
      end else begin
        chk("u4_data", outs4, exp4.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst && st3_q) begin
      chk("u3_stall_valid", 32'(outs_valid3), 32'd1);
      chk("u3_stall_data", outs3, prev3_q);
    end
    if (outs_valid3 && outs_ready3) begin
      if (exp3.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL u3_unexpected_token actual=%0h required=none", outs3);
      end else begin
        chk("u3_data", outs3, exp3.pop_front());
      end
    end
    st3_q   <= rst && outs_valid3 && !outs_ready3;
    prev3_q <= outs3;
  end

  task automatic push4(input logic [31:0] v);
    int n;
    n = 0;
    ins4 = v;
    ins_valid4 = 1'b1;
    exp4.push_back(v);
    @(negedge clk);
    while (!ins_ready4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push4_accept", 32'(ins_ready4), 32'd1);
    @(posedge clk);
    #1;
    ins_valid4 = 1'b0;
  endtask

  task automatic push3(input logic [31:0] v);
    int n;
    n = 0;
    ins3 = v;
    ins_valid3 = 1'b1;
    exp3.push_back(v);
    @(negedge clk);
    while (!ins_ready3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push3_accept", 32'(ins_ready3), 32'd1);
    @(posedge clk);
    #1;
    ins_valid3 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with ins_valid asserted.
    repeat (3) begin
      @(negedge clk);
      chk("rst_outs_valid", 32'(outs_valid4), 32'd0);
      chk("rst_ins_ready", 32'(ins_ready4), 32'd0);
      chk("rst_outs", outs4, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    ins_valid4 = 1'b0;
    @(negedge clk);
    chk("rel_ins_ready4", 32'(ins_ready4), 32'd1);
    chk("rel_ins_ready3", 32'(ins_ready3), 32'd1);
    chk("rel_outs_valid", 32'(outs_valid4), 32'd0);

    // Single token latency.
    @(posedge clk);
    #1;
    ins4 = 32'hA5;
    ins_valid4 = 1'b1;
    outs_ready4 = 1'b1;
    exp4.push_back(32'hA5);
    @(negedge clk);
    chk("lat_same_cycle_valid", 32'(outs_valid4), 32'(BYP));
    @(posedge clk);
    #1;
    ins_valid4 = 1'b0;
    @(negedge clk);
    chk("lat_next_cycle_valid", 32'(outs_valid4), 32'(!BYP));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("lat_drained", 32'(outs_valid4), 32'd0);
    chk("lat_queue", 32'(exp4.size()), 32'd0);

    // Fill to capacity; fifth token held upstream.
    @(posedge clk);
    #1;
    outs_ready4 = 1'b0;
    for (int i = 1; i <= 4; i++) push4(32'(i));
    ins4 = 32'd5;
    ins_valid4 = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("full_ins_ready", 32'(ins_ready4), 32'd0);
      chk("full_outs_valid", 32'(outs_valid4), 32'd1);
      chk("full_head", outs4, 32'd1);
      @(posedge clk);
      #1;
    end

    // Pop while full: no push that cycle, ready returns next cycle.
    outs_ready4 = 1'b1;
    @(negedge clk);
    chk("pop_full_ins_ready", 32'(ins_ready4), 32'd0);
    @(posedge clk);
    #1;
    ins_valid4 = 1'b0;
    @(negedge clk);
    chk("after_pop_ins_ready", 32'(ins_ready4), 32'd1);
    repeat (2) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("drain_valid", 32'(outs_valid4), 32'd1);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("drain_empty", 32'(outs_valid4), 32'd0);
    chk("drain_queue", 32'(exp4.size()), 32'd0);

    // Three-slot stream across pointer wrap with toggling ready.
    @(posedge clk);
    #1;
    outs_ready3 = 1'b1;
    fork
      begin
        for (int k = 0; k < 10; k++) push3(32'(k));
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1;
          outs_ready3 = ~outs_ready3;
        end
      end
    join
    @(negedge clk);
    chk("wrap_queue", 32'(exp3.size()), 32'd0);
    chk("wrap_empty", 32'(outs_valid3), 32'd0);

    // Asynchronous reset with tokens queued.
    @(posedge clk);
    #1;
    outs_ready3 = 1'b0;
    outs_ready4 = 1'b0;
    push4(32'd7);
    push4(32'd8);
    @(negedge clk);
    chk("pre_rst_valid", 32'(outs_valid4), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    exp4.delete();
    #1;
    chk("async_outs_valid", 32'(outs_valid4), 32'd0);
    chk("async_ins_ready", 32'(ins_ready4), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    outs_ready4 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_stale", 32'(outs_valid4), 32'd0);
    end
    @(posedge clk);
    #1;
    push4(32'd9);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post_rst_queue", 32'(exp4.size()), 32'd0);
    chk("post_rst_empty", 32'(outs_valid4), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
